// File: rtl/fp_cmd_sequencer.sv
// Purpose : queues FP commands {B, A, op} in a DEPTH-entry FIFO and runs them one at a time
//           through an external execution unit, trapping illegal opcodes and EU timeouts.
// Latency : a command written into an empty FIFO at cycle t gives eu_start at t+2 and res_valid at t+3+EU latency.
// Backpr. : cmd_ready drops while the FIFO is full. res_valid/res_data/res_err are held until res_ready.
//           The FIFO keeps accepting commands while a result waits.
//
// Ports:
//   clk, reset (async, active-low)
//   cmd_in/cmd_valid/cmd_ready      : command input, packed {B, A, op} with op in the LSBs
//   eu_start/eu_op/eu_a/eu_b        : dispatch to the execution unit (start is a one-cycle pulse)
//   eu_done/eu_result               : result strobe from the execution unit
//   res_data/res_err/res_valid/res_ready : result output (res_err = illegal opcode or timeout)
//   done                            : one-cycle pulse the cycle after a result handshake
//   busy, fifo_count                : status
//   stat_ok/stat_err                : saturating retire counters, present only when FP_SEQ_STATS_EN is defined
module fp_cmd_sequencer #(
  parameter int DATA_W  = 32,
  parameter int OP_W    = 2,
  parameter int DEPTH   = 4,
  parameter int NUM_OPS = 3,
  parameter int TIMEOUT = 64
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [2*DATA_W+OP_W-1:0]      cmd_in,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  output logic                          eu_start,
  output logic [OP_W-1:0]               eu_op,
  output logic [DATA_W-1:0]             eu_a,
  output logic [DATA_W-1:0]             eu_b,
  input  logic                          eu_done,
  input  logic [DATA_W-1:0]             eu_result,
  output logic [DATA_W-1:0]             res_data,
  output logic                          res_err,
  output logic                          res_valid,
  input  logic                          res_ready,
  output logic                          done,
  output logic                          busy,
  output logic [$clog2(DEPTH+1)-1:0]    fifo_count
`ifdef FP_SEQ_STATS_EN
  ,
  output logic [15:0]                   stat_ok,
  output logic [15:0]                   stat_err
`endif
);

  localparam int CMD_W = 2*DATA_W + OP_W;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int TMR_W = $clog2(TIMEOUT);

  localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(TIMEOUT-1);
  // One extra bit so NUM_OPS == 2**OP_W (every opcode legal) still compares correctly.
  localparam logic [OP_W:0]    NUM_OPS_L = (OP_W+1)'(NUM_OPS);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]       state;
  logic [CMD_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_nxt;
  logic             full_q;
  logic             push;
  logic             pop;
  logic             op_legal;
  logic [TMR_W-1:0] wait_cnt;

  // cmd_ready comes from a flop of the count, so a pop never opens room in the same cycle.
  // Gating with reset keeps it low while reset is held and high as soon as it lifts.
  assign cmd_ready = reset & ~full_q;
  assign push      = cmd_valid & cmd_ready;
  assign pop       = (state == S_IDLE) && (fifo_count != '0);
  assign count_nxt = fifo_count + CNT_W'(push) - CNT_W'(pop);

  assign op_legal  = ({1'b0, eu_op} < NUM_OPS_L);
  assign eu_start  = (state == S_ISSUE) && op_legal;
  assign res_valid = (state == S_RESP);
  assign busy      = (state != S_IDLE) || (fifo_count != '0);

  // Storage needs no reset: only entries below the count are ever read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= cmd_in;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      full_q     <= 1'b0;
    end else begin
      // DEPTH is a power of two, so pointers wrap naturally.
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      fifo_count <= count_nxt;
      full_q     <= (count_nxt == CNT_W'(DEPTH));
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      eu_op    <= '0;
      eu_a     <= '0;
      eu_b     <= '0;
      res_data <= '0;
      res_err  <= 1'b0;
      wait_cnt <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (fifo_count != '0) begin
            // Operand registers double as the EU drive, so they stay stable through WAIT.
            {eu_b, eu_a, eu_op} <= mem[rd_ptr];
            state               <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (op_legal) begin
            wait_cnt <= '0;
            state    <= S_WAIT;
          end else begin
            res_data <= '0;
            res_err  <= 1'b1;
            state    <= S_RESP;
          end
        end
        S_WAIT: begin
          // eu_done is checked first so it wins on the final timeout cycle.
          if (eu_done) begin
            res_data <= eu_result;
            res_err  <= 1'b0;
            state    <= S_RESP;
          end else if (wait_cnt == TMR_LAST) begin
            res_data <= '0;
            res_err  <= 1'b1;
            state    <= S_RESP;
          end else begin
            wait_cnt <= wait_cnt + TMR_W'(1);
          end
        end
        S_RESP: begin
          if (res_ready) begin
            done  <= 1'b1;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef FP_SEQ_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_ok  <= '0;
      stat_err <= '0;
    end else if (res_valid && res_ready) begin
      if (res_err) begin
        if (stat_err != 16'hFFFF) stat_err <= stat_err + 16'd1;
      end else begin
        if (stat_ok != 16'hFFFF) stat_ok <= stat_ok + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fp_cmd_sequencer.sv
module tb_fp_cmd_sequencer;
  localparam int DEPTH = 4;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int          lat;   // EU latency in cycles; 0 = EU never answers
    logic [31:0] res;
  } cmd_t;
  typedef struct {
    logic [31:0] d;
    logic        e;
  } exp_t;

  logic        clk = 0;
  logic        rst_n = 0;
  logic [65:0] cmd_in = '0;
  logic        cmd_valid = 0;
  logic        cmd_ready;
  logic        eu_start;
  logic [1:0]  eu_op;
  logic [31:0] eu_a, eu_b;
  logic        eu_done = 0;
  logic [31:0] eu_result = '0;
  logic [31:0] res_data;
  logic        res_err, res_valid;
  logic        res_ready = 0;
  logic        done, busy;
  logic [2:0]  fifo_count;
`ifdef FP_SEQ_STATS_EN
  logic [15:0] stat_ok, stat_err;
  int          ok_m = 0, err_m = 0;
`endif

  fp_cmd_sequencer dut (
    .clk(clk), .reset(rst_n), .cmd_in(cmd_in), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .eu_start(eu_start), .eu_op(eu_op), .eu_a(eu_a), .eu_b(eu_b),
    .eu_done(eu_done), .eu_result(eu_result),
    .res_data(res_data), .res_err(res_err), .res_valid(res_valid), .res_ready(res_ready),
    .done(done), .busy(busy), .fifo_count(fifo_count)
`ifdef FP_SEQ_STATS_EN
    , .stat_ok(stat_ok), .stat_err(stat_err)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;
  int cyc = 0;
  bit chk_en = 0;
  cmd_t eu_q[$];
  exp_t res_q[$];
  int eu_due = -1, late_cyc = -1;
  logic [31:0] eu_val = '0;
  int next_lat = 1;
  bit fixed_en = 0;
  logic [31:0] fixed_res = '0;
  bit done_exp = 0, prev_rv = 0;
  int done_cnt = 0, start_cnt = 0, start_cyc = 0, rv_cyc = 0;
  logic [31:0] last_d = '0;
  logic last_e = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, got, exp, cyc);
  endtask

  // Stand-in execution unit: its result is an arbitrary but reproducible mix of the operands.
  function automatic logic [31:0] eu_fn(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    return (a ^ {b[15:0], b[31:16]}) + 32'(op);
  endfunction

  // EU driver: pulses eu_done on the scheduled cycle (or a deliberately late stray one).
  always @(posedge clk) begin
    cyc++;
    #1;
    eu_done   = (cyc == eu_due) || (cyc == late_cyc);
    eu_result = eu_done ? eu_val : $urandom;
  end

  // Reference model and single compare point, sampled mid-cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("done", done, done_exp);
      if (done) done_cnt++;
      chk("busy", busy, res_q.size() != 0);
      chk("cmd_ready", cmd_ready, fifo_count != DEPTH);
      done_exp = 0;
      if (res_valid && !prev_rv) rv_cyc = cyc;
      prev_rv = res_valid;
      if (res_valid) begin
        if (res_q.size() == 0) chk("spurious_res_valid", 1, 0);
        else begin
          chk("res_data", res_data, res_q[0].d);
          chk("res_err", res_err, res_q[0].e);
          if (res_ready) begin
            last_d = res_data;
            last_e = res_err;
`ifdef FP_SEQ_STATS_EN
            if (res_q[0].e) err_m++; else ok_m++;
`endif
            void'(res_q.pop_front());
            done_exp = 1;
          end
        end
      end
      if (eu_start) begin
        start_cnt++;
        start_cyc = cyc;
        if (eu_q.size() == 0) chk("unexpected_eu_start", 1, 0);
        else begin
          cmd_t c;
          c = eu_q.pop_front();
          chk("eu_op", eu_op, c.op);
          chk("eu_a", eu_a, c.a);
          chk("eu_b", eu_b, c.b);
          eu_due = (c.lat == 0) ? -1 : cyc + c.lat;
          eu_val = c.res;
        end
      end
      if (cmd_valid && cmd_ready) begin
        cmd_t c;
        exp_t x;
        c.op  = cmd_in[1:0];
        c.a   = cmd_in[33:2];
        c.b   = cmd_in[65:34];
        c.lat = next_lat;
        c.res = fixed_en ? fixed_res : eu_fn(c.op, c.a, c.b);
        if (c.op >= 2'd3) begin
          x.d = '0; x.e = 1'b1;
        end else begin
          eu_q.push_back(c);
          // The unit gives up after 64 WAIT cycles; a reply on the 64th still counts.
          if (c.lat >= 1 && c.lat <= 64) begin x.d = c.res; x.e = 1'b0; end
          else begin x.d = '0; x.e = 1'b1; end
        end
        res_q.push_back(x);
      end
    end
  end

  // Called just after a rising edge; returns just after the edge that took the command.
  task automatic push_cmd(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input int lat);
    int g = 0;
    next_lat  = lat;
    cmd_in    = {b, a, op};
    cmd_valid = 1;
    @(negedge clk);
    while (!cmd_ready && g < 500) begin @(negedge clk); g++; end
    if (!cmd_ready) chk("push_timeout", 0, 1);
    @(posedge clk); #1;
    cmd_valid = 0;
  endtask

  task automatic drain(input int max);
    int g = 0;
    while (res_q.size() != 0 && g < max) begin @(posedge clk); #1; g++; end
    chk("drain_complete", res_q.size(), 0);
    repeat (2) begin @(posedge clk); #1; end
  endtask

  initial begin
    int t, d0, s0;
    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_eu_start", eu_start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_fifo_count", fifo_count, 0);
    @(posedge clk); #1;
    rst_n = 1;
    @(negedge clk);
    chk("post_rst_cmd_ready", cmd_ready, 1);
    chk_en = 1;
    @(posedge clk); #1;

    // 1: ADD with a 5-cycle EU
    res_ready = 1; fixed_en = 1; fixed_res = 32'h4100_0000;
    d0 = done_cnt; t = cyc;
    push_cmd(2'd0, 32'h40A0_0000, 32'h4040_0000, 5);
    fixed_en = 0;
    drain(100);
    chk("add_start_latency", start_cyc - t, 2);
    chk("add_resvalid_latency", rv_cyc - t, 8);
    chk("add_res_data", last_d, 32'h4100_0000);
    chk("add_res_err", last_e, 0);
    chk("add_done_pulses", done_cnt - d0, 1);

    // 2: stalled consumer, five back-to-back commands
    res_ready = 0; d0 = done_cnt;
    for (int i = 0; i < 5; i++) push_cmd(2'(i % 3), 32'h1000 + 32'(i), 32'h2000 + 32'(i), 3);
    @(negedge clk);
    chk("full_fifo_count", fifo_count, 4);
    chk("full_cmd_ready", cmd_ready, 0);
    @(posedge clk); #1;
    res_ready = 1;
    drain(200);
    chk("burst_done_pulses", done_cnt - d0, 5);

    // 3: illegal opcode
    s0 = start_cnt; d0 = done_cnt;
    push_cmd(2'd3, 32'h4000_0000, 32'h4080_0000, 1);
    drain(50);
    chk("illegal_no_start", start_cnt - s0, 0);
    chk("illegal_res_data", last_d, 0);
    chk("illegal_res_err", last_e, 1);
    chk("illegal_done", done_cnt - d0, 1);

    // 4: EU never answers, then a stray eu_done while idle
    push_cmd(2'd1, 32'h1234_5678, 32'h9ABC_DEF0, 0);
    drain(200);
    chk("timeout_wait_cycles", rv_cyc - start_cyc - 1, 64);
    chk("timeout_res_err", last_e, 1);
    chk("timeout_res_data", last_d, 0);
    s0 = start_cnt;
    late_cyc = cyc + 3;
    repeat (8) begin @(posedge clk); #1; end
    chk("late_done_ignored_rv", res_valid, 0);
    chk("late_done_ignored_busy", busy, 0);
    chk("late_done_no_start", start_cnt - s0, 0);

    // 5: reset pulse mid-WAIT with two queued commands
    push_cmd(2'd0, 32'hAAAA_0000, 32'h5555_0000, 0);
    push_cmd(2'd1, 32'h1, 32'h2, 2);
    push_cmd(2'd2, 32'h3, 32'h4, 2);
    repeat (2) begin @(posedge clk); #1; end
    @(negedge clk);
    chk("pre_rst_fifo_count", fifo_count, 2);
    @(posedge clk); #1;
    chk_en = 0;
    rst_n = 0;
    #1;
    chk("mid_rst_fifo_count", fifo_count, 0);
    chk("mid_rst_res_valid", res_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_eu_start", eu_start, 0);
`ifdef FP_SEQ_STATS_EN
    chk("mid_rst_stat_ok", stat_ok, 0);
    ok_m = 0; err_m = 0;
`endif
    @(posedge clk); #1;
    rst_n = 1;
    eu_q.delete(); res_q.delete();
    eu_due = -1; done_exp = 0; prev_rv = 0;
    chk_en = 1;
    push_cmd(2'd2, 32'h0BAD_F00D, 32'h0000_0003, 4);
    drain(50);
    chk("post_rst_res_data", last_d, eu_fn(2'd2, 32'h0BAD_F00D, 32'h0000_0003));
    chk("post_rst_res_err", last_e, 0);

    // 6: randomized traffic
    for (int i = 0; i < 900; i++) begin
      int r;
      r = $urandom_range(0, 39);
      next_lat  = (r == 0) ? 0 : (r == 1) ? 64 : (r == 2) ? 65 : $urandom_range(1, 8);
      cmd_in    = {32'($urandom), 32'($urandom), 2'($urandom_range(0, 3))};
      cmd_valid = ($urandom_range(0, 2) == 0);
      res_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    cmd_valid = 0; res_ready = 1;
    drain(2000);
    chk("final_eu_q_empty", eu_q.size(), 0);
`ifdef FP_SEQ_STATS_EN
    chk("stat_ok", stat_ok, ok_m);
    chk("stat_err", stat_err, err_m);
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish (checks %0d/%0d)", n_pass, n_chk);
    $fatal(1, "watchdog");
  end
endmodule
